// File: rtl/note_tone_gen.sv
// -----------------------------------------------------------------------------
// note_tone_gen
//
// Plays one note at a time on a square-wave output. A command carries a MIDI
// note number and a duration. The block looks up the note's half-period in an
// external note-period PROM (1-cycle synchronous read), then toggles tone_out
// every <period> tone ticks until the duration runs out or stop is raised.
//
// Time bases:
//   tone tick     = TICK_DIV clk cycles (10 us at 27 MHz / 270)
//   duration tick = DUR_DIV tone ticks  (1 ms at defaults)
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   note_valid  command valid
//   note_ready  block can accept a command (IDLE only)
//   note_num    MIDI note number, 0..127
//   note_dur    duration in duration ticks (0 = finish immediately)
//   stop        abort the current note (no done pulse)
//   rom_ad      PROM address
//   rom_ce      PROM clock enable, high for the single FETCH cycle
//   rom_oce     PROM output enable, tied high
//   rom_dout    PROM data: half-period in tone ticks (0 = rest)
//   tone_out    square-wave output
//   busy        high whenever the block is not IDLE
//   done        one-cycle pulse after a note completes normally
// -----------------------------------------------------------------------------
module note_tone_gen #(
  parameter int TICK_DIV = 270,
  parameter int DUR_DIV  = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        note_valid,
  output logic        note_ready,
  input  logic [6:0]  note_num,
  input  logic [15:0] note_dur,
  input  logic        stop,
  output logic [6:0]  rom_ad,
  output logic        rom_ce,
  output logic        rom_oce,
  input  logic [15:0] rom_dout,
  output logic        tone_out,
  output logic        busy,
  output logic        done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DUR_DIV > 1) ? $clog2(DUR_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DTICK_LAST = DW'(DUR_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   dur_cnt;
  logic [15:0]   period;
  logic [15:0]   half_cnt;
  logic [PW-1:0] presc;
  logic [DW-1:0] dtick;

  logic tick;
  logic dur_tick;
  logic accept;
  logic finish;

  // Status and PROM control are pure decodes of the state register.
  assign note_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign rom_ce     = (state == S_FETCH);
  assign rom_oce    = 1'b1;
  assign accept     = note_valid && note_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and time-base strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of always_comb; a branch that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    tick      = (state == S_PLAY) && (presc == PRESC_LAST);
    dur_tick  = tick && (dtick == DTICK_LAST);

    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        state_nxt = stop ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (dur_cnt == 16'd0) begin
          // Zero-length note: complete without ever entering PLAY.
          state_nxt = S_IDLE;
          finish    = 1'b1;
        end else begin
          state_nxt = S_PLAY;
        end
      end
      S_PLAY: begin
        // stop wins over a note end landing in the same cycle.
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (dur_tick && dur_cnt == 16'd1) begin
          state_nxt = S_IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: command capture, period latch, prescalers, square wave
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_ad   <= '0;
      dur_cnt  <= '0;
      period   <= '0;
      half_cnt <= '0;
      presc    <= '0;
      dtick    <= '0;
      tone_out <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= finish;

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            rom_ad  <= note_num;
            dur_cnt <= note_dur;
          end
        end
        S_FETCH: begin
          // PROM captures rom_ad at the edge closing this cycle.
        end
        S_WAIT: begin
          period   <= rom_dout;
          half_cnt <= '0;
          presc    <= '0;
          dtick    <= '0;
          tone_out <= 1'b0;
        end
        S_PLAY: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) begin
            // period == 0 is a rest: the counter and output stay parked.
            if (period != 16'd0) begin
              if (half_cnt == period - 16'd1) begin
                half_cnt <= '0;
                tone_out <= ~tone_out;
              end else begin
                half_cnt <= half_cnt + 16'd1;
              end
            end
            dtick <= dur_tick ? '0 : dtick + DW'(1);
          end
          if (dur_tick) dur_cnt <= dur_cnt - 16'd1;
        end
        default: ;
      endcase

      // Any exit to IDLE (normal end or stop) leaves the pin low.
      if (state != S_IDLE && state_nxt == S_IDLE) tone_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_note_tone_gen
//
// Three instances share clock, reset, note_num/note_dur and stop; each has its
// own valid, outputs and PROM model:
//   u0: TICK_DIV=2, DUR_DIV=4
//   u1: TICK_DIV=2, DUR_DIV=200
//   u2: TICK_DIV=2, DUR_DIV=8
// Expected behaviour comes from closed-form timing: after the WAIT->PLAY edge
// E2, k edges later tone_out = floor(k / (period*TICK_DIV)) mod 2, and the note
// ends at edge E2 + dur*DUR_DIV*TICK_DIV.
// -----------------------------------------------------------------------------
module tb_note_tone_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stop;
  logic [6:0]  note_num;
  logic [15:0] note_dur;

  logic        note_valid [3];
  logic        note_ready [3];
  logic        rom_ce     [3];
  logic        rom_oce    [3];
  logic        tone_out   [3];
  logic        busy       [3];
  logic        done       [3];
  logic [6:0]  rom_ad     [3];
  logic [15:0] rom_dout   [3];

  int n_checks = 0;
  int n_errors = 0;
  bit rest_mode = 1'b0;
  int rom_tab [128];
  int ce_cnt  [3];

  always #5 clk = ~clk;

  note_tone_gen #(.TICK_DIV(2), .DUR_DIV(4)) u0 (
    .clk(clk), .reset(reset), .note_valid(note_valid[0]), .note_ready(note_ready[0]),
    .note_num(note_num), .note_dur(note_dur), .stop(stop), .rom_ad(rom_ad[0]),
    .rom_ce(rom_ce[0]), .rom_oce(rom_oce[0]), .rom_dout(rom_dout[0]),
    .tone_out(tone_out[0]), .busy(busy[0]), .done(done[0]));

  note_tone_gen #(.TICK_DIV(2), .DUR_DIV(200)) u1 (
    .clk(clk), .reset(reset), .note_valid(note_valid[1]), .note_ready(note_ready[1]),
    .note_num(note_num), .note_dur(note_dur), .stop(stop), .rom_ad(rom_ad[1]),
    .rom_ce(rom_ce[1]), .rom_oce(rom_oce[1]), .rom_dout(rom_dout[1]),
    .tone_out(tone_out[1]), .busy(busy[1]), .done(done[1]));

  note_tone_gen #(.TICK_DIV(2), .DUR_DIV(8)) u2 (
    .clk(clk), .reset(reset), .note_valid(note_valid[2]), .note_ready(note_ready[2]),
    .note_num(note_num), .note_dur(note_dur), .stop(stop), .rom_ad(rom_ad[2]),
    .rom_ce(rom_ce[2]), .rom_oce(rom_oce[2]), .rom_dout(rom_dout[2]),
    .tone_out(tone_out[2]), .busy(busy[2]), .done(done[2]));

  // Behavioural PROMs: 1-cycle synchronous read gated by rom_ce.
  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (rom_ce[c] === 1'b1) begin
        rom_dout[c] <= rest_mode ? 16'h0000 : 16'(rom_tab[rom_ad[c]]);
        ce_cnt[c]   <= ce_cnt[c] + 1;
      end
    end
  end

  function automatic int td_of(input int c);
    return 2;
  endfunction

  function automatic int dd_of(input int c);
    case (c)
      0:       return 4;
      1:       return 200;
      default: return 8;
    endcase
  endfunction

  // Issue one command on instance c; returns at the negedge inside FETCH.
  task automatic start_cmd(input int c, input int num, input int dur);
    @(negedge clk);
    note_num      = 7'(num);
    note_dur      = 16'(dur);
    note_valid[c] = 1'b1;
    n_checks++;
    if (note_ready[c] !== 1'b1) begin
      n_errors++;
      $display("FAIL start_ready u%0d: note_ready=%b required 1", c, note_ready[c]);
    end
    @(negedge clk);
    note_valid[c] = 1'b0;
  endtask

  // Entered at the negedge inside FETCH; returns at the negedge of the first
  // cycle after the note is over (done cycle, or the cycle after a stop).
  task automatic check_play(input int c, input int num, input int p,
                            input int dur, input int stop_k);
    int ce0;
    int len;
    logic [3:0] exp_v;
    logic [3:0] got_v;
    ce0 = ce_cnt[c];
    len = dur * dd_of(c) * td_of(c);

    n_checks++;
    if ({rom_ce[c], rom_ad[c], busy[c], note_ready[c]} !== {1'b1, 7'(num), 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL fetch u%0d: rom_ce=%b rom_ad=%0d busy=%b ready=%b required 1/%0d/1/0",
               c, rom_ce[c], rom_ad[c], busy[c], note_ready[c], num);
    end

    @(negedge clk);
    n_checks++;
    if ({rom_ce[c], busy[c], tone_out[c]} !== 3'b010) begin
      n_errors++;
      $display("FAIL wait u%0d: rom_ce=%b busy=%b tone=%b required 0/1/0",
               c, rom_ce[c], busy[c], tone_out[c]);
    end

    @(negedge clk);
    for (int k = 0; k <= len; k++) begin
      stop  = 1'b0;
      got_v = {busy[c], done[c], tone_out[c], note_ready[c]};
      if (stop_k >= 0 && k == stop_k + 1) begin
        exp_v = 4'b0001;
      end else if (k == len) begin
        exp_v = 4'b0101;
      end else if (p == 0) begin
        exp_v = 4'b1000;
      end else begin
        exp_v = {2'b10, 1'((k / (p * td_of(c))) % 2), 1'b0};
      end
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL play u%0d note=%0d k=%0d: busy/done/tone/ready=%b required %b",
                 c, num, k, got_v, exp_v);
      end
      if (exp_v[3] == 1'b0) break;
      if (stop_k >= 0 && k == stop_k) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;

    n_checks++;
    if (ce_cnt[c] - ce0 !== 1) begin
      n_errors++;
      $display("FAIL rom_ce_count u%0d: %0d cycles required 1", c, ce_cnt[c] - ce0);
    end
  endtask

  // Settled-idle check one cycle after a note finished.
  task automatic check_idle(input int c, input string tag);
    @(negedge clk);
    n_checks++;
    if ({busy[c], done[c], tone_out[c], note_ready[c], rom_ce[c]} !== 5'b00010) begin
      n_errors++;
      $display("FAIL %s u%0d: busy/done/tone/ready/ce=%b required 00010",
               tag, c, {busy[c], done[c], tone_out[c], note_ready[c], rom_ce[c]});
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({tone_out[c], done[c], busy[c], note_ready[c], rom_ad[c], rom_ce[c], rom_oce[c]}
          !== {1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b1}) begin
        n_errors++;
        $display("FAIL %s u%0d: tone=%b done=%b busy=%b ready=%b ad=%0d ce=%b oce=%b required 0 0 0 1 0 0 1",
                 tag, c, tone_out[c], done[c], busy[c], note_ready[c], rom_ad[c], rom_ce[c], rom_oce[c]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
  endtask

  task automatic test_a440();
    start_cmd(0, 69, 3);
    check_play(0, 69, 114, 3, -1);
    check_idle(0, "a440_short_idle");
    // Longer duration base so the 228-clk half-periods are visible.
    start_cmd(1, 69, 3);
    check_play(1, 69, 114, 3, -1);
    check_idle(1, "a440_long_idle");
  endtask

  task automatic test_top_note();
    start_cmd(2, 127, 2);
    check_play(2, 127, 4, 2, -1);
    check_idle(2, "top_note_idle");
  endtask

  task automatic test_zero_dur();
    start_cmd(0, 60, 0);
    check_play(0, 60, rom_tab[60], 0, -1);
    check_idle(0, "zero_dur_idle");
  endtask

  task automatic test_stop();
    start_cmd(0, 69, 3);
    check_play(0, 69, 114, 3, 10);
    repeat (3) check_idle(0, "stop_no_done");
  endtask

  task automatic test_rest();
    rest_mode = 1'b1;
    start_cmd(2, 100, 2);
    check_play(2, 100, 0, 2, -1);
    rest_mode = 1'b0;
    check_idle(2, "rest_idle");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    note_num      = 7'd64;
    note_dur      = 16'd1;
    note_valid[2] = 1'b1;
    @(negedge clk);
    // valid stays high; the next command waits in front of the busy block.
    note_num = 7'd65;
    check_play(2, 64, rom_tab[64], 1, -1);
    @(negedge clk);
    note_valid[2] = 1'b0;
    check_play(2, 65, rom_tab[65], 1, -1);
    repeat (3) check_idle(2, "b2b_no_extra");
  endtask

  task automatic test_reset_mid();
    start_cmd(2, 127, 2);
    @(negedge clk);           // WAIT
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset_in_wait");

    start_cmd(2, 127, 2);
    repeat (6) @(negedge clk); // a few cycles into PLAY
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset_in_play");
    repeat (2) check_idle(2, "reset_no_done");

    start_cmd(2, 127, 2);
    check_play(2, 127, 4, 2, -1);
    check_idle(2, "after_reset_idle");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int c, num, dur, len, sk;
      c   = ($urandom_range(0, 1) == 0) ? 0 : 2;
      num = $urandom_range(96, 127);
      dur = $urandom_range(0, 3);
      len = dur * dd_of(c) * td_of(c);
      sk  = -1;
      if (len > 2 && $urandom_range(0, 3) == 0) sk = $urandom_range(0, len - 2);
      start_cmd(c, num, dur);
      check_play(c, num, rom_tab[num], dur, sk);
      check_idle(c, "random_idle");
    end
  endtask

  initial begin
    for (int n = 0; n < 128; n++)
      rom_tab[n] = $rtoi(100000.0 / (880.0 * (2.0 ** ((n - 69) / 12.0))) + 0.5);
    for (int c = 0; c < 3; c++) begin
      note_valid[c] = 1'b0;
      ce_cnt[c]     = 0;
    end
    reset    = 1'b1;
    stop     = 1'b0;
    note_num = '0;
    note_dur = '0;

    test_reset();
    test_a440();
    test_top_note();
    test_zero_dur();
    test_stop();
    test_rest();
    test_back_to_back();
    test_reset_mid();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Downstream consumer of the 128-entry note-period PROM (7-bit note number in, 16-bit half-period out, 1-cycle synchronous read).
- Accepts note commands (note number plus duration) over a valid/ready handshake.
- Fetches the half-period from the PROM, then drives a square-wave tone output for the commanded duration.
- Feeds the speaker/buzzer pin; a sequencer upstream issues the commands.

Parameters:
- TICK_DIV, 270, clk cycles per tone tick. 27 MHz / 270 = 100 kHz; PROM values are half-periods in 10 µs ticks.
- DUR_DIV, 100, tone ticks per duration tick (1 ms at defaults).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- note_valid  in  1  command valid.
- note_ready  out  1  block can accept a command.
- note_num  in  7  MIDI note number, 0..127.
- note_dur  in  16  duration in duration ticks.
- stop  in  1  abort current note.
- rom_ad  out  7  PROM address.
- rom_ce  out  1  PROM clock enable.
- rom_oce  out  1  PROM output enable; constant 1.
- rom_dout  in  16  PROM data (half-period).
- tone_out  out  1  square-wave output.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a note completes normally.

Behaviour:
- Reset: state=IDLE; tone_out=0, done=0, busy=0, note_ready=1, rom_ad=0, rom_ce=0; all counters=0.
- Handshake: accept when note_valid && note_ready, sampled at clk edge. note_ready=1 only in IDLE. No command queueing.
- FSM states: IDLE, FETCH, WAIT, PLAY.
- IDLE -> FETCH on accept. Register note_num into rom_ad and note_dur into dur_cnt.
- FETCH: rom_ce=1 for exactly this cycle; the PROM captures rom_ad at the closing edge. Next state is WAIT.
- WAIT: rom_dout is valid. At the closing edge, latch period=rom_dout; clear tick/half/dur-tick counters; tone_out=0. Next state is PLAY.
- Latency: accept edge E0, rom_ce high during E0..E1, period latched at E2, PLAY from E2.
- Tone tick: prescaler counts 0..TICK_DIV-1 in PLAY; tick when it equals TICK_DIV-1, then it wraps to 0.
- Square wave: on each tick, if half_cnt==period-1 then toggle tone_out and set half_cnt=0, else half_cnt+1. Full period = 2*period ticks.
- Rest: period==0 means tone_out is held 0 for the whole duration.
- Duration: a duration tick occurs every DUR_DIV tone ticks.
  - On each duration tick, decrement dur_cnt.
  - When dur_cnt is 1 on a duration tick, the note ends.
- Note end: tone_out=0; done=1 for one cycle (registered, asserted in the cycle after the transition edge); state=IDLE.
- note_dur==0: at the WAIT->PLAY edge go straight to IDLE instead, with done pulse; no toggles.
- stop: if high in FETCH, WAIT or PLAY, go to IDLE at the next edge with tone_out=0 and no done. In IDLE, stop is ignored. stop has priority over note end in the same cycle.
- Simultaneous events: in the done cycle the block is IDLE, so note_ready=1 and a new command may be accepted in that same cycle.
- Reset mid-operation: returns to the reset state at the next edge regardless of state; no done pulse.
- Widths: half_cnt 16 bits; the prescaler sized by $clog2(TICK_DIV); the duration-tick counter sized by $clog2(DUR_DIV); no overflow is possible because half_cnt < period <= 0xFFFF.

Test Plan (TICK_DIV=2, DUR_DIV=4, behavioural PROM model with standard table):
- Note 69, dur 3 -> rom_ad=69; rom_ce high exactly 1 cycle; period latched =0x0072 (114); tone_out toggles every 228 clks; done pulses once after 3*4*2=24 clks of PLAY. The 24-clk PLAY window ends before the first toggle, so the bench also repeats with DUR_DIV=200 and checks 228-clk half-periods.
- Note 127 (period 4), dur 2, DUR_DIV=8 -> toggles every 8 clks; 4 toggles over 32 clks of PLAY; tone_out=0 and done=1 in the following cycle.
- note_dur=0, note 60 -> no toggles; done one cycle after the WAIT->PLAY edge (3 cycles after accept); busy drops.
- stop asserted 10 clks into PLAY -> IDLE next edge; tone_out=0; done never pulses; note_ready=1.
- note_valid held high with back-to-back commands (notes 64 then 65) -> second accepted in the done cycle; second rom_ce 1 cycle later; no command lost or duplicated.
- reset pulsed in WAIT and again in PLAY -> all outputs return to their reset values next edge; no done pulse; the next command completes normally.
